combine_sched: RTL and testbench
================================

Name: combine_sched

Overview:
- Scheduler/arbiter that shares one 25→50-bit word-pair packer between two 25-bit coefficient producers.
- Grants one producer at a time for a fixed-length burst and sequences the pair-accumulate step itself.
- Emits packed 50-bit words over a valid/ready handshake, each tagged with its source.
- Sits between two coefficient lanes and the 50-bit memory/bus write path.

Parameters:
- DW, 25, width of one input word
- BURST, 256, words per granted burst; must be even and ≥2
- CW, $clog2(BURST), width of the burst word counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[i] = producer i requests a burst; level, held until granted
- din0  in  DW  producer 0 data
- din0_valid  in  1  producer 0 word valid
- din0_ready  out  1  producer 0 word accepted when valid&ready
- din1  in  DW  producer 1 data
- din1_valid  in  1  producer 1 word valid
- din1_ready  out  1  producer 1 word accepted when valid&ready
- gnt  out  2  one-hot current grant; 0 when idle
- busy  out  1  burst in progress
- dout  out  2*DW  packed pair {first word, second word}; first word in bits [2*DW-1:DW]
- dout_valid  out  1  dout holds an unconsumed pair
- dout_ready  in  1  consumer accepts when dout_valid&dout_ready
- dout_src  out  1  producer index of the pair in dout

Behaviour:
- Reset (async): state=IDLE, gnt=0, busy=0, din*_ready=0, dout=0, dout_valid=0, dout_src=0, word counter=0, half-pair register empty, last_gnt=1 (so producer 0 wins the first tie).
- FSM IDLE:
  - If req≠0, register grant and go to BUSY next cycle.
  - If only one requester is active, grant it.
  - If both are active, grant the one ≠ last_gnt (round-robin).
  - On grant, set last_gnt to the granted index.
- FSM BUSY:
  - dinG_ready = 1 for the granted producer G, except when the half-pair register is full AND dout_valid=1 AND dout_ready=0. The non-granted producer's ready is always 0.
  - First word of a pair is stored in the half-pair register.
  - Second word of a pair: on the next edge, dout ← {half, dinG}, dout_valid ← 1, dout_src ← G, half-pair register cleared.
  - Latency: dout_valid rises 1 cycle after the second word's handshake.
  - Simultaneous dout consume and second-word accept in the same cycle is allowed: the new pair overwrites dout, dout_valid stays 1, with no bubble.
  - Word counter increments per accepted word and wraps to 0 after BURST-1.
  - On the accepting edge of word BURST-1: gnt ← 0, busy ← 0, state ← IDLE.
  - A pending pair in dout persists across re-arbitration; the next burst may fill the half-pair register while dout is still held.
- dout_valid clears on dout_valid&dout_ready with no new pair in the same cycle. dout, dout_src and dout_valid are stable while dout_valid=1 and dout_ready=0.
- req is ignored during BUSY; a requester that drops req before grant is not granted.
- Since BURST is even, no partial pair exists at a burst boundary.
- Asserting rst mid-burst discards the half-pair and any pending dout immediately; nothing is emitted afterwards.
- Valid words from a non-granted producer are never consumed.

Decomposition:
- Shared package holds: DW, the packed-width constant 2*DW, the state encoding (IDLE, BUSY), and the producer index type.
- One natural sub-module: pair_packer. It holds the half-pair register plus the output register with the valid/ready handshake, driven by an accept strobe and the granted data/source.
- combine_sched holds the arbiter, FSM and burst counter.

Test Plan:
- Reset/idle: assert rst mid-cycle → all outputs 0 asynchronously; with req=00 for 10 cycles, gnt=00 and no ready.
- Single burst (BURST=4): req=01, din0=1,2,3,4 each cycle, dout_ready=1 → dout=0x2000002 (src 0), then 0x6000004; gnt returns to 00 after the 4th word.
- Round-robin: req=11 held for three bursts → grant order 0,1,0; dout_src follows; no word from the idle producer is consumed.
- Backpressure: dout_ready=0 after the first pair → din_ready drops once the half-pair register is full. Raising dout_ready consumes 0x2000002 and accepts the 4th word in the same cycle, with no lost or duplicated words.
- Reset mid-burst: rst asserted after word 3 of 4 → dout_valid=0, gnt=00; the next burst starts a fresh pair and counter.
- Odd data/width: din=0x1FFFFFF then 0 → dout=0x3FFFFFE000000; a following pair of 0 then 0x1FFFFFF → dout=0x1FFFFFF (bit-exact packing).

Source files
------------

// File: rtl/combine_sched_pkg.sv
// Shared constants and types for the two-producer pair-packing scheduler.
package combine_sched_pkg;

  localparam int DW = 25;
  localparam int PW = 2 * DW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef logic src_t;

endpackage

// File: rtl/combine_sched_if.sv
// Producer lanes, grant status and packed output handshake of combine_sched.
interface combine_sched_if;
  import combine_sched_pkg::*;

  logic [1:0]    req;
  logic [DW-1:0] din0;
  logic          din0_valid;
  logic          din0_ready;
  logic [DW-1:0] din1;
  logic          din1_valid;
  logic          din1_ready;
  logic [1:0]    gnt;
  logic          busy;
  logic [PW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  src_t          dout_src;

  modport master (
    output req, din0, din0_valid, din1, din1_valid, dout_ready,
    input  din0_ready, din1_ready, gnt, busy, dout, dout_valid, dout_src
  );

  modport slave (
    input  req, din0, din0_valid, din1, din1_valid, dout_ready,
    output din0_ready, din1_ready, gnt, busy, dout, dout_valid, dout_src
  );

endinterface

// File: rtl/combine_sched_pair_packer.sv
// Half-pair register plus output register: joins two accepted words into one
// tagged pair and holds it until the consumer takes it.
module pair_packer
  import combine_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic [DW-1:0] data,
  input  src_t          src,
  input  logic          dout_ready,
  output logic          space,
  output logic [PW-1:0] dout,
  output logic          dout_valid,
  output src_t          dout_src
);

  logic [DW-1:0] half;
  logic          half_full;

  // A second word may only land if the output slot is free or being drained now.
  assign space = !(half_full && dout_valid && !dout_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half       <= '0;
      half_full  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_src   <= 1'b0;
    end else begin
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;
      if (accept) begin
        if (half_full) begin
          dout       <= {half, data};
          dout_valid <= 1'b1;
          dout_src   <= src;
          half       <= '0;
          half_full  <= 1'b0;
        end else begin
          half       <= data;
          half_full  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/combine_sched.sv
// Round-robin burst arbiter sharing one pair packer between two producers.
//   state   | meaning
//   ST_IDLE | no burst; arbitrate pending requests
//   ST_BUSY | granted producer streams BURST words into the packer
module combine_sched
  import combine_sched_pkg::*;
#(
  parameter int BURST = 256,
  parameter int CW    = $clog2(BURST)
) (
  input logic            clk,
  input logic            rst,
  combine_sched_if.slave bus
);

  state_t        state;
  logic [1:0]    gnt_r;
  logic          busy_r;
  logic [CW-1:0] cnt;
  src_t          last_gnt;
  src_t          pick;
  src_t          g;
  logic          sel_valid;
  logic [DW-1:0] sel_data;
  logic          space;
  logic          accept;
  logic [PW-1:0] pk_dout;
  logic          pk_valid;
  src_t          pk_src;

  assign g         = gnt_r[1];
  assign sel_valid = g ? bus.din1_valid : bus.din0_valid;
  assign sel_data  = g ? bus.din1 : bus.din0;
  assign accept    = busy_r && space && sel_valid;

  assign bus.din0_ready = busy_r && gnt_r[0] && space;
  assign bus.din1_ready = busy_r && gnt_r[1] && space;
  assign bus.gnt        = gnt_r;
  assign bus.busy       = busy_r;
  assign bus.dout       = pk_dout;
  assign bus.dout_valid = pk_valid;
  assign bus.dout_src   = pk_src;

  // Tie goes to whoever was not served last.
  always_comb begin
    pick = bus.req[1];
    if (bus.req == 2'b11)
      pick = ~last_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_r    <= 2'b00;
      busy_r   <= 1'b0;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_r    <= pick ? 2'b10 : 2'b01;
            last_gnt <= pick;
            busy_r   <= 1'b1;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            if (cnt == CW'(BURST - 1)) begin
              cnt    <= '0;
              gnt_r  <= 2'b00;
              busy_r <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pair_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .data       (sel_data),
    .src        (g),
    .dout_ready (bus.dout_ready),
    .space      (space),
    .dout       (pk_dout),
    .dout_valid (pk_valid),
    .dout_src   (pk_src)
  );

endmodule

// File: tb/tb_combine_sched.sv
// Self-checking bench for combine_sched with BURST=4: directed steps plus
// randomized handshakes checked against a burst/pair reference model.
module tb_combine_sched;
  import combine_sched_pkg::*;

  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  combine_sched_if bus ();

  combine_sched #(.BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] s0[$];
  logic [DW-1:0] s1[$];
  int            p0, p1;
  int            m0, m1;
  logic [PW:0]   got[$];
  logic [PW:0]   exp_q[$];
  int            glog[$];
  int            exp_g[$];
  bit            rand_vld, rand_rdy, fixed_rdy;
  int            rr_left;
  logic [1:0]    prev_gnt;
  int            viol;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic drive();
    bus.din0       = (p0 < s0.size()) ? s0[p0] : '0;
    bus.din0_valid = (p0 < s0.size()) && (!rand_vld || ($urandom_range(3) != 0));
    bus.din1       = (p1 < s1.size()) ? s1[p1] : '0;
    bus.din1_valid = (p1 < s1.size()) && (!rand_vld || ($urandom_range(3) != 0));
    bus.dout_ready = rand_rdy ? ($urandom_range(1) == 1) : fixed_rdy;
  endtask

  // One clock: sample handshakes at negedge, commit them at posedge, redrive.
  task automatic tick();
    bit          a0, a1, ao;
    logic [PW:0] pair;
    @(negedge clk);
    a0   = bus.din0_valid && bus.din0_ready;
    a1   = bus.din1_valid && bus.din1_ready;
    ao   = bus.dout_valid && bus.dout_ready;
    pair = {bus.dout_src, bus.dout};
    if ((bus.din0_ready && !bus.gnt[0]) || (bus.din1_ready && !bus.gnt[1]))
      viol++;
    if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
      glog.push_back(int'(bus.gnt[1]));
      if (rr_left > 0) begin
        rr_left--;
        if (rr_left == 0)
          bus.req = 2'b00;
      end
    end
    prev_gnt = bus.gnt;
    @(posedge clk);
    if (a0) p0++;
    if (a1) p1++;
    if (ao) got.push_back(pair);
    #1 drive();
  endtask

  // Reference: a burst from producer p takes its next BURST words, in pairs.
  task automatic model_burst(input int p);
    for (int k = 0; k < BURST / 2; k++) begin
      if (p == 0) begin
        exp_q.push_back({1'b0, s0[m0], s0[m0+1]});
        m0 += 2;
      end else begin
        exp_q.push_back({1'b1, s1[m1], s1[m1+1]});
        m1 += 2;
      end
    end
  endtask

  task automatic wait_pairs(input int n, input int budget, input string tag);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, got.size(), n);
  endtask

  task automatic compare_pairs(input string tag);
    logic [63:0] obs;
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size())
        obs = 64'(got[i]);
      check(tag, obs, 64'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic reset_streams();
    s0.delete();
    s1.delete();
    p0 = 0; p1 = 0; m0 = 0; m1 = 0;
    glog.delete();
    exp_g.delete();
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int last, w, c;
    bus.req = 2'b00;
    rand_vld = 0; rand_rdy = 0; fixed_rdy = 0;
    rr_left = 0; prev_gnt = 2'b00; viol = 0;
    reset_streams();
    drive();

    // async reset mid-cycle
    #3 rst = 1'b1;
    #1 check("reset_outputs",
             {bus.gnt, bus.busy, bus.dout_valid, bus.dout_src, bus.din0_ready, bus.din1_ready, bus.dout},
             64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (10) begin
      tick();
      check("idle_no_grant", {bus.gnt, bus.din0_ready, bus.din1_ready}, 64'd0);
    end

    // round-robin, both requesting for three bursts, random handshakes
    reset_streams();
    for (int i = 0; i < 3 * BURST; i++) s0.push_back(DW'($urandom));
    for (int i = 0; i < 2 * BURST; i++) s1.push_back(DW'($urandom));
    last = 1;
    for (int b = 0; b < 3; b++) begin
      w = 1 - last;
      exp_g.push_back(w);
      model_burst(w);
      last = w;
    end
    rand_vld = 1; rand_rdy = 1;
    bus.req = 2'b11; rr_left = 3; viol = 0;
    drive();
    wait_pairs(3 * BURST / 2, 600, "rr_wait");
    rand_rdy = 0; fixed_rdy = 1;
    repeat (10) tick();
    check("rr_grant_count", glog.size(), 3);
    for (int i = 0; i < 3; i++)
      check("rr_grant_order", (i < glog.size()) ? glog[i] : -1, exp_g[i]);
    check("rr_words_p0", p0, 2 * BURST);
    check("rr_words_p1", p1, BURST);
    check("rr_idle_ready", viol, 0);
    compare_pairs("rr_pair");
    rand_vld = 0;

    // single burst, data 1..4
    reset_streams();
    s0 = '{25'd1, 25'd2, 25'd3, 25'd4};
    model_burst(0);
    fixed_rdy = 1; bus.req = 2'b01; rr_left = 1;
    drive();
    wait_pairs(2, 50, "single_wait");
    check("single_gnt_done", {bus.gnt, bus.busy}, 64'd0);
    check("single_words", p0, 4);
    compare_pairs("single_pair");
    repeat (2) tick();

    // backpressure: consumer stalls after the first pair
    reset_streams();
    s0 = '{25'd1, 25'd2, 25'd3, 25'd4};
    model_burst(0);
    fixed_rdy = 0; bus.req = 2'b01; rr_left = 1;
    drive();
    c = 0;
    while (p0 < 3 && c < 50) begin tick(); c++; end
    check("bp_three_words", p0, 3);
    repeat (3) tick();
    check("bp_ready_low", bus.din0_ready, 0);
    check("bp_still_three", p0, 3);
    check("bp_held_pair", {bus.dout_valid, bus.dout}, {1'b1, 50'h2000002});
    fixed_rdy = 1; bus.dout_ready = 1'b1;
    tick();
    check("bp_same_cycle_word", p0, 4);
    check("bp_same_cycle_out", got.size(), 1);
    check("bp_no_bubble", bus.dout_valid, 1);
    wait_pairs(2, 20, "bp_wait");
    compare_pairs("bp_pair");
    repeat (2) tick();

    // reset after word 3 of 4 discards everything
    reset_streams();
    for (int i = 0; i < BURST; i++) s0.push_back(DW'($urandom));
    fixed_rdy = 0; bus.req = 2'b01; rr_left = 1;
    drive();
    c = 0;
    while (p0 < 3 && c < 50) begin tick(); c++; end
    check("mr_three_words", p0, 3);
    check("mr_pending_before", bus.dout_valid, 1);
    rst = 1'b1;
    #1 check("mr_reset_outputs",
             {bus.gnt, bus.busy, bus.dout_valid, bus.din0_ready, bus.din1_ready, bus.dout},
             64'd0);
    fixed_rdy = 1;
    tick();
    tick();
    rst = 1'b0;
    check("mr_nothing_emitted", got.size(), 0);
    reset_streams();
    for (int i = 0; i < BURST; i++) s0.push_back(DW'($urandom));
    model_burst(0);
    bus.req = 2'b01; rr_left = 1;
    drive();
    wait_pairs(2, 50, "mr_wait");
    compare_pairs("mr_fresh_pair");
    repeat (2) tick();

    // bit-exact packing at the extremes
    reset_streams();
    s0 = '{25'h1FFFFFF, 25'h0, 25'h0, 25'h1FFFFFF};
    exp_q.push_back({1'b0, 50'h3FFFFFE000000});
    exp_q.push_back({1'b0, 50'h00000001FFFFFF});
    bus.req = 2'b01; rr_left = 1;
    drive();
    wait_pairs(2, 50, "odd_wait");
    compare_pairs("odd_pair");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
